// File: rtl/snake_if.sv
// Write port of the 15x15 world memory shared with the VGA reader.
// The game engine drives it (master); the memory samples it (slave).
interface snake_if;
    logic       writeEnable;
    logic [3:0] x_loc_sw;
    logic [3:0] y_loc_sw;
    logic [1:0] data_in;

    modport master (output writeEnable, x_loc_sw, y_loc_sw, data_in);
    modport slave  (input  writeEnable, x_loc_sw, y_loc_sw, data_in);
endinterface

// File: rtl/snake_engine.sv
// Snake game logic: owns body ring, occupancy bitmap, food and direction,
// and turns each movement tick into single-cycle cell writes on the world memory.
module snake_engine (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] dir_in,
    snake_if.master    mem,
    output logic       busy,
    output logic       game_over,
    output logic       win,
    output logic [7:0] score
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_INIT, S_RUN_WAIT, S_STEP,
        S_MOVE, S_EAT, S_FOOD_SEARCH, S_FOOD_WRITE, S_GAME_OVER
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [1:0] CODE_EMPTY = 2'b00;
    localparam logic [1:0] CODE_FOOD  = 2'b01;
    localparam logic [1:0] CODE_SNAKE = 2'b10;

    state_t       state_q, state_d;
    logic [3:0]   cx_q, cy_q;
    logic [1:0]   phase_q;
    logic [7:0]   body_q [256];
    logic [7:0]   head_ptr_q, tail_ptr_q, len_q;
    logic [224:0] occ_q;
    logic [3:0]   head_x_q, head_y_q, nh_x_q, nh_y_q, food_x_q, food_y_q;
    logic [1:0]   dir_q, pend_dir_q;
    logic [7:0]   lfsr_q;
    logic         we_q, busy_q, go_q, win_q;
    logic [3:0]   wx_q, wy_q;
    logic [1:0]   wd_q;
    logic [7:0]   score_q;

    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] xe, ye;
        xe = {4'd0, x} - 8'd1;
        ye = {4'd0, y} - 8'd1;
        return (ye << 4) - ye + xe;
    endfunction

    logic [4:0] sx, sy;
    logic       out_of_range, step_hit, food_hit, cand_ok, lfsr_fb;
    logic [7:0] tail_cell;
    logic [3:0] cand_x, cand_y;

    always_comb begin
        sx = {1'b0, head_x_q};
        sy = {1'b0, head_y_q};
        case (pend_dir_q)
            2'b00:   sy = sy - 5'd1;
            2'b01:   sy = sy + 5'd1;
            2'b10:   sx = sx - 5'd1;
            default: sx = sx + 5'd1;
        endcase
    end

    assign out_of_range = (sx == 5'd0) || (sx > 5'd15) || (sy == 5'd0) || (sy > 5'd15);
    // Tail bit is still set here, so chasing the tail is a collision.
    assign step_hit  = out_of_range || occ_q[cell_idx(sx[3:0], sy[3:0])];
    assign food_hit  = (sx[3:0] == food_x_q) && (sy[3:0] == food_y_q);
    assign cand_x    = lfsr_q[3:0];
    assign cand_y    = lfsr_q[7:4];
    assign cand_ok   = (cand_x != 4'd0) && (cand_y != 4'd0) && !occ_q[cell_idx(cand_x, cand_y)];
    assign tail_cell = body_q[tail_ptr_q];
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (start) state_d = S_CLEAR;
            S_CLEAR:       if (cx_q == 4'd15 && cy_q == 4'd15) state_d = S_INIT;
            S_INIT:        if (phase_q == 2'd3) state_d = S_RUN_WAIT;
            S_RUN_WAIT:    if (tick) state_d = S_STEP;
            S_STEP:        state_d = step_hit ? S_GAME_OVER : (food_hit ? S_EAT : S_MOVE);
            S_MOVE:        if (phase_q == 2'd1) state_d = S_RUN_WAIT;
            S_EAT:         state_d = (len_q == 8'd224) ? S_GAME_OVER : S_FOOD_SEARCH;
            S_FOOD_SEARCH: if (cand_ok) state_d = S_FOOD_WRITE;
            S_FOOD_WRITE:  state_d = S_RUN_WAIT;
            S_GAME_OVER:   if (start) state_d = S_CLEAR;
            default:       state_d = S_IDLE;
        endcase
    end

    logic       body_we;
    logic [7:0] body_addr, body_wdata;

    always_comb begin
        body_we    = 1'b0;
        body_addr  = head_ptr_q + 8'd1;
        body_wdata = {nh_y_q, nh_x_q};
        case (state_q)
            S_INIT: if (phase_q != 2'd3) begin
                body_we    = 1'b1;
                body_addr  = {6'd0, phase_q};
                body_wdata = {4'd1, {2'b00, phase_q} + 4'd1};
            end
            S_MOVE:  body_we = (phase_q == 2'd1);
            S_EAT:   body_we = 1'b1;
            default: body_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (body_we) body_q[body_addr] <= body_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cx_q       <= 4'd1;
            cy_q       <= 4'd1;
            phase_q    <= 2'd0;
            head_ptr_q <= 8'd0;
            tail_ptr_q <= 8'd0;
            len_q      <= 8'd0;
            occ_q      <= '0;
            head_x_q   <= 4'd0;
            head_y_q   <= 4'd0;
            nh_x_q     <= 4'd0;
            nh_y_q     <= 4'd0;
            food_x_q   <= 4'd0;
            food_y_q   <= 4'd0;
            dir_q      <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            lfsr_q     <= 8'hA5;
            we_q       <= 1'b0;
            wx_q       <= 4'd0;
            wy_q       <= 4'd0;
            wd_q       <= CODE_EMPTY;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
            win_q      <= 1'b0;
            score_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[6:0], lfsr_fb};
            we_q    <= 1'b0;
            busy_q  <= !(state_d inside {S_IDLE, S_RUN_WAIT, S_GAME_OVER});
            go_q    <= (state_d == S_GAME_OVER);
            if (dir_in != {dir_q[1], ~dir_q[0]}) pend_dir_q <= dir_in;

            case (state_q)
                S_IDLE, S_GAME_OVER: if (start) begin
                    cx_q    <= 4'd1;
                    cy_q    <= 4'd1;
                    win_q   <= 1'b0;
                    score_q <= 8'd0;
                end
                S_CLEAR: begin
                    we_q    <= 1'b1;
                    wx_q    <= cx_q;
                    wy_q    <= cy_q;
                    wd_q    <= CODE_EMPTY;
                    occ_q   <= '0;
                    phase_q <= 2'd0;
                    if (cx_q == 4'd15) begin
                        cx_q <= 4'd1;
                        cy_q <= cy_q + 4'd1;
                    end else begin
                        cx_q <= cx_q + 4'd1;
                    end
                end
                S_INIT: begin
                    we_q       <= 1'b1;
                    phase_q    <= phase_q + 2'd1;
                    dir_q      <= DIR_RIGHT;
                    pend_dir_q <= DIR_RIGHT;
                    if (phase_q != 2'd3) begin
                        wx_q           <= {2'b00, phase_q} + 4'd1;
                        wy_q           <= 4'd1;
                        wd_q           <= CODE_SNAKE;
                        occ_q[phase_q] <= 1'b1;
                    end else begin
                        wx_q       <= 4'd3;
                        wy_q       <= 4'd3;
                        wd_q       <= CODE_FOOD;
                        food_x_q   <= 4'd3;
                        food_y_q   <= 4'd3;
                        head_x_q   <= 4'd3;
                        head_y_q   <= 4'd1;
                        tail_ptr_q <= 8'd0;
                        head_ptr_q <= 8'd2;
                        len_q      <= 8'd3;
                        score_q    <= 8'd0;
                    end
                end
                S_STEP: begin
                    nh_x_q  <= sx[3:0];
                    nh_y_q  <= sy[3:0];
                    dir_q   <= pend_dir_q;
                    phase_q <= 2'd0;
                end
                S_MOVE: begin
                    we_q <= 1'b1;
                    if (phase_q == 2'd0) begin
                        wx_q    <= tail_cell[3:0];
                        wy_q    <= tail_cell[7:4];
                        wd_q    <= CODE_EMPTY;
                        occ_q[cell_idx(tail_cell[3:0], tail_cell[7:4])] <= 1'b0;
                        tail_ptr_q <= tail_ptr_q + 8'd1;
                        phase_q <= 2'd1;
                    end else begin
                        wx_q       <= nh_x_q;
                        wy_q       <= nh_y_q;
                        wd_q       <= CODE_SNAKE;
                        occ_q[cell_idx(nh_x_q, nh_y_q)] <= 1'b1;
                        head_ptr_q <= head_ptr_q + 8'd1;
                        head_x_q   <= nh_x_q;
                        head_y_q   <= nh_y_q;
                        phase_q    <= 2'd0;
                    end
                end
                S_EAT: begin
                    we_q       <= 1'b1;
                    wx_q       <= nh_x_q;
                    wy_q       <= nh_y_q;
                    wd_q       <= CODE_SNAKE;
                    occ_q[cell_idx(nh_x_q, nh_y_q)] <= 1'b1;
                    head_ptr_q <= head_ptr_q + 8'd1;
                    head_x_q   <= nh_x_q;
                    head_y_q   <= nh_y_q;
                    len_q      <= len_q + 8'd1;
                    score_q    <= score_q + 8'd1;
                    if (len_q == 8'd224) win_q <= 1'b1;
                end
                // The 01 write goes out on the accepting edge; FOOD_WRITE only retires it.
                S_FOOD_SEARCH: if (cand_ok) begin
                    we_q     <= 1'b1;
                    wx_q     <= cand_x;
                    wy_q     <= cand_y;
                    wd_q     <= CODE_FOOD;
                    food_x_q <= cand_x;
                    food_y_q <= cand_y;
                end
                default: ;
            endcase
        end
    end

    assign mem.writeEnable = we_q;
    assign mem.x_loc_sw    = wx_q;
    assign mem.y_loc_sw    = wy_q;
    assign mem.data_in     = wd_q;
    assign busy            = busy_q;
    assign game_over       = go_q;
    assign win             = win_q;
    assign score           = score_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: expected cell writes are queued when a start or tick
// is driven and checked in order (with cycle stamps) as the write port fires.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir_in = 2'b11;
    logic       busy, game_over, win;
    logic [7:0] score;

    snake_if sif ();

    snake_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .dir_in    (dir_in),
        .mem       (sif),
        .busy      (busy),
        .game_over (game_over),
        .win       (win),
        .score     (score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    localparam int K_MOVE = 0;
    localparam int K_EAT  = 1;
    localparam int K_OVER = 2;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] code;
        bit         any_food;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
    } cell_t;

    typedef struct {
        logic [1:0] dir;
        int         kind;
        logic [3:0] hx;
        logic [3:0] hy;
    } vec_t;

    wr_t        exp_q[$];
    cell_t      snake_m[$];
    vec_t       tab_a[$];
    wr_t        mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_score = 0;
    logic [3:0] food_x = 4'd3;
    logic [3:0] food_y = 4'd3;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit on_snake(input logic [3:0] x, input logic [3:0] y);
        foreach (snake_m[i]) if (snake_m[i].x == x && snake_m[i].y == y) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (sif.writeEnable) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: actual x=%0d y=%0d code=%0d required no write (cycle %0d)",
                         sif.x_loc_sw, sif.y_loc_sw, sif.data_in, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.any_food) begin
                    chk("food_code", int'(sif.data_in), 1);
                    chk("food_x_nonzero", int'(sif.x_loc_sw != 4'd0), 1);
                    chk("food_y_nonzero", int'(sif.y_loc_sw != 4'd0), 1);
                    chk("food_on_free_cell", int'(on_snake(sif.x_loc_sw, sif.y_loc_sw)), 0);
                    food_x = sif.x_loc_sw;
                    food_y = sif.y_loc_sw;
                end else begin
                    chk("write_x", int'(sif.x_loc_sw), int'(mon_e.x));
                    chk("write_y", int'(sif.y_loc_sw), int'(mon_e.y));
                    chk("write_code", int'(sif.data_in), int'(mon_e.code));
                    chk("write_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic wait_quiet(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_settle"}, int'(done), 1);
    endtask

    task automatic do_start(output int n);
        int k;
        n = cyc + 1;
        k = 0;
        for (int y = 1; y <= 15; y++) begin
            for (int x = 1; x <= 15; x++) begin
                exp_q.push_back('{4'(x), 4'(y), 2'b00, 1'b0, n + 1 + k});
                k++;
            end
        end
        exp_q.push_back('{4'd1, 4'd1, 2'b10, 1'b0, n + 226});
        exp_q.push_back('{4'd2, 4'd1, 2'b10, 1'b0, n + 227});
        exp_q.push_back('{4'd3, 4'd1, 2'b10, 1'b0, n + 228});
        exp_q.push_back('{4'd3, 4'd3, 2'b01, 1'b0, n + 229});
        snake_m = {};
        snake_m.push_back('{4'd1, 4'd1});
        snake_m.push_back('{4'd2, 4'd1});
        snake_m.push_back('{4'd3, 4'd1});
        food_x    = 4'd3;
        food_y    = 4'd3;
        exp_score = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_tick(input string name, input logic [1:0] dir, input int kind,
                           input logic [3:0] hx, input logic [3:0] hy);
        int    t;
        cell_t tl;
        t      = cyc + 1;
        dir_in = dir;
        tick   = 1'b1;
        if (kind == K_MOVE) begin
            tl = snake_m.pop_front();
            exp_q.push_back('{tl.x, tl.y, 2'b00, 1'b0, t + 2});
            exp_q.push_back('{hx, hy, 2'b10, 1'b0, t + 3});
            snake_m.push_back('{hx, hy});
        end else if (kind == K_EAT) begin
            exp_q.push_back('{hx, hy, 2'b10, 1'b0, t + 2});
            snake_m.push_back('{hx, hy});
            exp_q.push_back('{4'd0, 4'd0, 2'b01, 1'b1, -1});
            exp_score++;
        end
        @(negedge clk);
        tick = 1'b0;
        wait_quiet(name);
        chk({name, "_score"}, int'(score), exp_score);
        chk({name, "_game_over"}, int'(game_over), int'(kind == K_OVER));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int t;
        for (int x = 4; x <= 6; x++) tab_a.push_back('{2'b11, K_MOVE, 4'(x), 4'd1});
        tab_a.push_back('{2'b10, K_MOVE, 4'd7, 4'd1});
        for (int x = 8; x <= 15; x++) tab_a.push_back('{2'b11, K_MOVE, 4'(x), 4'd1});
        tab_a.push_back('{2'b11, K_OVER, 4'd0, 4'd0});

        repeat (3) @(negedge clk);
        chk("rst_writeEnable", int'(sif.writeEnable), 0);
        chk("rst_x_loc", int'(sif.x_loc_sw), 0);
        chk("rst_y_loc", int'(sif.y_loc_sw), 0);
        chk("rst_data", int'(sif.data_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_score", int'(score), 0);
        rst = 1'b0;
        @(negedge clk);

        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tick_busy", int'(busy), 0);

        // Game A: straight run to the right wall, with a reverse request and
        // stray tick/start pulses during CLEAR that must be dropped.
        do_start(n);
        chk("start_busy", int'(busy), 1);
        repeat (10) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 228) @(negedge clk);
        chk("busy_last_init", int'(busy), 1);
        @(negedge clk);
        chk("busy_after_init", int'(busy), 0);
        wait_quiet("game_a_init");
        chk("game_a_score0", int'(score), 0);
        foreach (tab_a[i]) do_tick($sformatf("game_a_tick%0d", i), tab_a[i].dir, tab_a[i].kind,
                                   tab_a[i].hx, tab_a[i].hy);
        chk("game_a_win", int'(win), 0);
        repeat (3) @(negedge clk);
        chk("game_a_go_holds", int'(game_over), 1);

        // Game B: restart from GAME_OVER, eat the food, then run into the tail.
        do_start(n);
        wait_quiet("game_b_init");
        chk("game_b_go_cleared", int'(game_over), 0);
        do_tick("b_down1", 2'b01, K_MOVE, 4'd3, 4'd2);
        do_tick("b_eat", 2'b01, K_EAT, 4'd3, 4'd3);
        if ((food_x == 4'd2) && (food_y == 4'd3 || food_y == 4'd2)) begin
            do_tick("b_right", 2'b11, K_MOVE, 4'd4, 4'd3);
            do_tick("b_up", 2'b00, K_MOVE, 4'd4, 4'd2);
            do_tick("b_left_tail", 2'b10, K_OVER, 4'd0, 4'd0);
        end else begin
            do_tick("b_left", 2'b10, K_MOVE, 4'd2, 4'd3);
            do_tick("b_up", 2'b00, K_MOVE, 4'd2, 4'd2);
            do_tick("b_right_tail", 2'b11, K_OVER, 4'd0, 4'd0);
        end
        chk("game_b_win", int'(win), 0);

        // Game C: reset lands while the engine is looking for a food cell.
        do_start(n);
        wait_quiet("game_c_init");
        do_tick("c_down1", 2'b01, K_MOVE, 4'd3, 4'd2);
        t      = cyc + 1;
        dir_in = 2'b01;
        tick   = 1'b1;
        exp_q.push_back('{4'd3, 4'd3, 2'b10, 1'b0, t + 2});
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("c_eat_score", int'(score), 1);
        chk("c_search_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("c_rst_writeEnable", int'(sif.writeEnable), 0);
        chk("c_rst_x_loc", int'(sif.x_loc_sw), 0);
        chk("c_rst_y_loc", int'(sif.y_loc_sw), 0);
        chk("c_rst_data", int'(sif.data_in), 0);
        chk("c_rst_busy", int'(busy), 0);
        chk("c_rst_score", int'(score), 0);
        chk("c_rst_game_over", int'(game_over), 0);
        rst = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (20) @(negedge clk);
        chk("c_idle_busy", int'(busy), 0);
        chk("leftover_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
# snake_engine

Game-logic writer for the 15x15 snake world memory. It holds the snake body, food position and direction. On each movement tick it advances the snake and issues single-cycle cell writes (x, y, 2-bit code) on the memory's write port. The VGA side independently reads the same memory for display.

## Interface
- No parameters; board fixed at 15x15, coordinates 1..15 on both axes, 2-bit cell codes 00 empty, 01 food, 10 snake.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new game from IDLE or GAME_OVER, ignored elsewhere
- tick  in  1  one-cycle movement strobe; honoured only in RUN_WAIT, otherwise dropped (no queuing)
- dir_in  in  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- writeEnable  out  1  memory write strobe, high exactly one cycle per write
- x_loc_sw  out  4  write column, 1..15, valid when writeEnable
- y_loc_sw  out  4  write row, 1..15, valid when writeEnable
- data_in  out  2  cell code written, valid when writeEnable
- busy  out  1  high in every state except IDLE, RUN_WAIT, GAME_OVER
- game_over  out  1  high while in GAME_OVER
- win  out  1  high in GAME_OVER when length reached 225
- score  out  8  foods eaten (length - 3), saturates never needed (max 222)

## Operation
- Body stored as circular buffer, 256 entries x 8 bits ({y,x}), 8-bit head/tail pointers, length counter; 225-bit occupancy bitmap mirrors snake cells.
- Direction: dir_in sampled every cycle into pending_dir unless it is the 180° reverse of current dir (then ignored). pending_dir becomes dir at each step.
- States:
  - IDLE: outputs quiet. start -> CLEAR.
  - CLEAR: writes 00 to all 225 cells, row-major (y 1..15 outer, x 1..15 inner), one per cycle. Then -> INIT.
  - INIT: 4 writes, one per cycle: 10 at (1,1), (2,1), (3,1), then 01 at (3,3). Tail=(1,1), head=(3,1), dir=right, length=3, score=0. Then -> RUN_WAIT.
  - RUN_WAIT: tick -> STEP.
  - STEP: compute next head from dir.
    - Outside 1..15 or occupied in bitmap (tail cell counts as occupied) -> GAME_OVER.
    - Equals food -> EAT.
    - Else -> MOVE.
  - MOVE: cycle 1 writes 00 at tail, clears bitmap bit, advances tail. Cycle 2 writes 10 at new head, sets bit, pushes head. Then -> RUN_WAIT.
  - EAT: writes 10 at new head, length+1, score+1. If length==225 -> GAME_OVER with win=1, else -> FOOD_SEARCH.
  - FOOD_SEARCH: candidate x=lfsr[3:0], y=lfsr[7:4]. Accept if both nonzero and cell unoccupied -> FOOD_WRITE; else retry next cycle.
  - FOOD_WRITE: writes 01 at candidate, records food position -> RUN_WAIT.
  - GAME_OVER: no writes. start -> CLEAR (clears win, score).
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst, advances every cycle (all states), never zero.
- start or tick in any state other than those listed is ignored.

## Timing
- Reset values:
  - state IDLE
  - writeEnable 0, x_loc_sw 0, y_loc_sw 0, data_in 00
  - busy 0, game_over 0, win 0, score 0
  - pointers 0, bitmap clear
- All outputs registered. The write strobe appears the cycle after entering the writing state.
- Game start: start at cycle N -> first CLEAR write at N+1, last (15,15) at N+225, INIT writes N+226..N+229, RUN_WAIT from N+230.
- Plain move: tick at T -> tail clear at T+2, head write at T+3, ready for next tick at T+4.
- Eat: head write at T+2, food write at T+3+k, where k is the number of rejected candidates.
- Reset asserted mid-game aborts immediately; no further writes; state IDLE next cycle.
- Simultaneous tick and dir_in change: dir_in registered the same cycle, so it takes effect for that step.

## Test plan
- Reset then start -> exactly 225 writes of 00 in row-major order, then 10@(1,1), 10@(2,1), 10@(3,1), 01@(3,3); busy falls after INIT.
- Three ticks, dir right -> per tick, writes 00@tail then 10@head: heads (4,1), (5,1), (6,1); tails (1,1), (2,1), (3,1); score 0.
- Right to x=15, then one more tick -> game_over=1, no write that step; start recovers to the CLEAR sequence.
- Steer down at x=3 to reach (3,3) -> 10@(3,3) with no tail clear, score=1, then one 01 write at an unoccupied cell with nonzero coordinates.
- dir_in=left while moving right -> ignored, next head x+1. Tick during CLEAR -> dropped, no extra writes.
- Reset asserted during FOOD_SEARCH -> all outputs zero next cycle, state IDLE.
